// File: rtl/ctrl_decode_stage_pkg.sv
// Shared encodings for the ID/EX control decode stage: opcodes, ALU ops, regDst codes,
// the registered control bundle and the SYSCALL sequencer states.
package ctrl_decode_stage_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL     = 6'h00;
  localparam logic [5:0] FN_SRL     = 6'h02;
  localparam logic [5:0] FN_SRA     = 6'h03;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_SLT     = 6'h2A;

  // ALU codes are 4 bits here and resized to ALUOP_W at the decoder output.
  localparam logic [3:0] ALU_NOP = 4'd0;
  localparam logic [3:0] ALU_ADD = 4'd1;
  localparam logic [3:0] ALU_SUB = 4'd2;
  localparam logic [3:0] ALU_AND = 4'd3;
  localparam logic [3:0] ALU_OR  = 4'd4;
  localparam logic [3:0] ALU_SLT = 4'd5;
  localparam logic [3:0] ALU_SLL = 4'd6;
  localparam logic [3:0] ALU_SRL = 4'd7;
  localparam logic [3:0] ALU_SRA = 4'd8;
  localparam logic [3:0] ALU_LUI = 4'd9;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FIRE  = 2'd2
  } sys_state_e;

  typedef struct packed {
    logic [1:0] reg_dst;
    logic [4:0] wreg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       branch;
    logic       bne;
    logic       jump;
    logic       jal;
    logic       jr;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/ctrl_decode_stage_comb.sv
// Pure combinational decode table: instruction word -> control bundle, ALU op, rt-use and syscall flags.
// No state, no handshake; undecodable words produce a bundle with only the illegal flag set.
module ctrl_decode_comb
  import ctrl_decode_stage_pkg::*;
#(
  parameter int ALUOP_W       = 4,
  parameter int SUPPORT_SHIFT = 1
) (
  input  logic [31:0]        instr_i,
  output ctrl_t              ctrl_o,
  output logic [ALUOP_W-1:0] aluop_o,
  output logic               uses_rt_o,
  output logic               is_sys_o
);

  localparam bit SHIFT_EN = (SUPPORT_SHIFT != 0);

  logic [5:0] op;
  logic [5:0] fn;
  logic [4:0] rt;
  logic [4:0] rd;
  logic [3:0] alu;
  logic       r_alu;
  logic       i_alu;
  logic       illegal;
  logic       unused_fields;

  assign op = instr_i[31:26];
  assign fn = instr_i[5:0];
  assign rt = instr_i[20:16];
  assign rd = instr_i[15:11];
  // rs and shamt only matter to the hazard compare and the ALU, not to decode.
  assign unused_fields = ^{instr_i[25:21], instr_i[10:6]};

  always_comb begin
    ctrl_o    = '0;
    alu       = ALU_NOP;
    r_alu     = 1'b0;
    i_alu     = 1'b0;
    illegal   = 1'b0;
    uses_rt_o = 1'b0;
    is_sys_o  = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADD, FN_ADDU: begin r_alu = 1'b1; alu = ALU_ADD; end
          FN_SUB:          begin r_alu = 1'b1; alu = ALU_SUB; end
          FN_AND:          begin r_alu = 1'b1; alu = ALU_AND; end
          FN_OR:           begin r_alu = 1'b1; alu = ALU_OR;  end
          FN_SLT:          begin r_alu = 1'b1; alu = ALU_SLT; end
          FN_SLL: if (SHIFT_EN) begin r_alu = 1'b1; alu = ALU_SLL; end else illegal = 1'b1;
          FN_SRL: if (SHIFT_EN) begin r_alu = 1'b1; alu = ALU_SRL; end else illegal = 1'b1;
          FN_SRA: if (SHIFT_EN) begin r_alu = 1'b1; alu = ALU_SRA; end else illegal = 1'b1;
          FN_JR:      ctrl_o.jr = 1'b1;
          FN_SYSCALL: is_sys_o  = 1'b1;
          default:    illegal   = 1'b1;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin i_alu = 1'b1; alu = ALU_ADD; end
      OP_ORI:            begin i_alu = 1'b1; alu = ALU_OR;  end
      OP_LUI:            begin i_alu = 1'b1; alu = ALU_LUI; end
      OP_LW: begin
        i_alu             = 1'b1;
        alu               = ALU_ADD;
        ctrl_o.mem_read   = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      OP_SW: begin
        alu              = ALU_ADD;
        ctrl_o.mem_write = 1'b1;
        ctrl_o.alu_src   = 1'b1;
        uses_rt_o        = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        alu           = ALU_SUB;
        ctrl_o.branch = 1'b1;
        ctrl_o.bne    = (op == OP_BNE);
        uses_rt_o     = 1'b1;
      end
      OP_J: ctrl_o.jump = 1'b1;
      OP_JAL: begin
        ctrl_o.jump      = 1'b1;
        ctrl_o.jal       = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = RD_RA;
        ctrl_o.wreg      = 5'd31;
      end
      default: illegal = 1'b1;
    endcase
    if (r_alu) begin
      ctrl_o.reg_dst   = RD_RD;
      ctrl_o.reg_write = 1'b1;
      ctrl_o.wreg      = rd;
      uses_rt_o        = 1'b1;
    end
    if (i_alu) begin
      ctrl_o.reg_dst   = RD_RT;
      ctrl_o.reg_write = 1'b1;
      ctrl_o.wreg      = rt;
      ctrl_o.alu_src   = 1'b1;
    end
    ctrl_o.illegal = illegal;
  end

  assign aluop_o = ALUOP_W'(alu);

endmodule

// File: rtl/ctrl_decode_stage.sv
// ID/EX control stage: registers the decoded bundle (latency 1), inserts load-use bubbles and sequences SYSCALL.
// Backpressure: ex_stall holds the output register and drops in_ready; flush squashes and wins over everything.
module ctrl_decode_stage
  import ctrl_decode_stage_pkg::*;
#(
  parameter int ALUOP_W       = 4,
  parameter int DRAIN_CYCLES  = 3,
  parameter int SUPPORT_SHIFT = 1
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        instr,
  input  logic               ex_stall,
  input  logic               flush,
  output logic               out_valid,
  output logic [1:0]         out_regDst,
  output logic [4:0]         out_wreg,
  output logic               out_regWrite,
  output logic               out_memRead,
  output logic               out_memWrite,
  output logic               out_memToReg,
  output logic               out_ALUSrc,
  output logic [ALUOP_W-1:0] out_ALUop,
  output logic               out_branch,
  output logic               out_bne,
  output logic               out_jump,
  output logic               out_jal,
  output logic               out_jr,
  output logic               out_illegal,
  output logic               sys_fire
);

  localparam int CNT_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

  ctrl_t              dec_ctrl;
  logic [ALUOP_W-1:0] dec_alu;
  logic               dec_uses_rt;
  logic               dec_sys;

  ctrl_t              bun_q;
  logic [ALUOP_W-1:0] alu_q;
  logic               vld_q;
  sys_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               hazard;
  logic               accept;

  ctrl_decode_comb #(
    .ALUOP_W       (ALUOP_W),
    .SUPPORT_SHIFT (SUPPORT_SHIFT)
  ) u_dec (
    .instr_i   (instr),
    .ctrl_o    (dec_ctrl),
    .aluop_o   (dec_alu),
    .uses_rt_o (dec_uses_rt),
    .is_sys_o  (dec_sys)
  );

  // The load in EX cannot forward in time to a consumer still in ID.
  assign hazard = vld_q && bun_q.mem_read && (bun_q.wreg != 5'd0) &&
                  ((bun_q.wreg == instr[25:21]) || (dec_uses_rt && (bun_q.wreg == instr[20:16])));

  assign in_ready = !ex_stall && !hazard && (state_q == ST_IDLE);
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept && dec_sys) begin
            state_d = (DRAIN_CYCLES == 0) ? ST_FIRE : ST_DRAIN;
            cnt_d   = CNT_W'(DRAIN_CYCLES);
          end
        end
        ST_DRAIN: begin
          if (!ex_stall) begin
            if (cnt_q <= CNT_W'(1)) begin
              state_d = ST_FIRE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
        end
        ST_FIRE: state_d = ST_IDLE;
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      vld_q <= 1'b0;
      bun_q <= '0;
      alu_q <= '0;
    end else if (flush) begin
      vld_q <= 1'b0;
    end else if (!ex_stall) begin
      vld_q <= accept;
      if (accept) begin
        bun_q <= dec_ctrl;
        alu_q <= dec_alu;
      end
    end
  end

  // A flush in the FIRE cycle cancels the strobe along with everything else.
  assign sys_fire = (state_q == ST_FIRE) && !flush;

  assign out_valid    = vld_q;
  assign out_regDst   = bun_q.reg_dst;
  assign out_wreg     = bun_q.wreg;
  assign out_regWrite = bun_q.reg_write;
  assign out_memRead  = bun_q.mem_read;
  assign out_memWrite = bun_q.mem_write;
  assign out_memToReg = bun_q.mem_to_reg;
  assign out_ALUSrc   = bun_q.alu_src;
  assign out_ALUop    = alu_q;
  assign out_branch   = bun_q.branch;
  assign out_bne      = bun_q.bne;
  assign out_jump     = bun_q.jump;
  assign out_jal      = bun_q.jal;
  assign out_jr       = bun_q.jr;
  assign out_illegal  = bun_q.illegal;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Bench: two stage instances (shift+3-cycle drain, no-shift+zero drain) on shared stimulus,
// checked every cycle against a per-instance behavioural model plus directed literal expectations.
module tb_ctrl_decode_stage;
  import ctrl_decode_stage_pkg::*;

  typedef struct packed {
    logic [1:0] rdst;
    logic [4:0] wreg;
    logic       rw, mr, mw, m2r, asrc;
    logic [3:0] alu;
    logic       br, bne, j, jal, jr, ill;
  } bun_t;

  logic        clk = 1'b1;
  logic        rst_b, in_valid, ex_stall, flush;
  logic [31:0] instr;

  logic       in_ready [2];
  logic       out_valid [2];
  logic [1:0] out_regDst [2];
  logic [4:0] out_wreg [2];
  logic       out_regWrite [2], out_memRead [2], out_memWrite [2], out_memToReg [2], out_ALUSrc [2];
  logic [3:0] out_ALUop [2];
  logic       out_branch [2], out_bne [2], out_jump [2], out_jal [2], out_jr [2], out_illegal [2];
  logic       sys_fire [2];

  int n_chk = 0;
  int n_pass = 0;

  bit   ev [2];
  bun_t eb [2];
  bit   insys [2];
  int   dl [2];

  always #5 clk = ~clk;

  ctrl_decode_stage #(.ALUOP_W(4), .DRAIN_CYCLES(3), .SUPPORT_SHIFT(1)) dut (
    .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .in_ready(in_ready[0]), .instr(instr),
    .ex_stall(ex_stall), .flush(flush), .out_valid(out_valid[0]), .out_regDst(out_regDst[0]),
    .out_wreg(out_wreg[0]), .out_regWrite(out_regWrite[0]), .out_memRead(out_memRead[0]),
    .out_memWrite(out_memWrite[0]), .out_memToReg(out_memToReg[0]), .out_ALUSrc(out_ALUSrc[0]),
    .out_ALUop(out_ALUop[0]), .out_branch(out_branch[0]), .out_bne(out_bne[0]), .out_jump(out_jump[0]),
    .out_jal(out_jal[0]), .out_jr(out_jr[0]), .out_illegal(out_illegal[0]), .sys_fire(sys_fire[0]));

  ctrl_decode_stage #(.ALUOP_W(4), .DRAIN_CYCLES(0), .SUPPORT_SHIFT(0)) dut_ns (
    .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .in_ready(in_ready[1]), .instr(instr),
    .ex_stall(ex_stall), .flush(flush), .out_valid(out_valid[1]), .out_regDst(out_regDst[1]),
    .out_wreg(out_wreg[1]), .out_regWrite(out_regWrite[1]), .out_memRead(out_memRead[1]),
    .out_memWrite(out_memWrite[1]), .out_memToReg(out_memToReg[1]), .out_ALUSrc(out_ALUSrc[1]),
    .out_ALUop(out_ALUop[1]), .out_branch(out_branch[1]), .out_bne(out_bne[1]), .out_jump(out_jump[1]),
    .out_jal(out_jal[1]), .out_jr(out_jr[1]), .out_illegal(out_illegal[1]), .sys_fire(sys_fire[1]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  function automatic bun_t rr(input logic [4:0] rd, input logic [3:0] alu);
    bun_t b = '0;
    b.rdst = 2'b01; b.rw = 1'b1; b.wreg = rd; b.alu = alu;
    return b;
  endfunction

  function automatic bun_t imm(input logic [4:0] rt, input logic [3:0] alu);
    bun_t b = '0;
    b.rdst = 2'b00; b.rw = 1'b1; b.wreg = rt; b.alu = alu; b.asrc = 1'b1;
    return b;
  endfunction

  function automatic bun_t ill();
    bun_t b = '0;
    b.ill = 1'b1;
    return b;
  endfunction

  function automatic bun_t dec(input logic [31:0] w, input bit sh);
    bun_t b;
    logic [4:0] rt, rd;
    rt = w[20:16];
    rd = w[15:11];
    b = '0;
    case (w[31:26])
      6'h00: case (w[5:0])
        6'h20, 6'h21: b = rr(rd, ALU_ADD);
        6'h22: b = rr(rd, ALU_SUB);
        6'h24: b = rr(rd, ALU_AND);
        6'h25: b = rr(rd, ALU_OR);
        6'h2A: b = rr(rd, ALU_SLT);
        6'h00: b = sh ? rr(rd, ALU_SLL) : ill();
        6'h02: b = sh ? rr(rd, ALU_SRL) : ill();
        6'h03: b = sh ? rr(rd, ALU_SRA) : ill();
        6'h08: b.jr = 1'b1;
        6'h0C: b = '0;
        default: b = ill();
      endcase
      6'h08, 6'h09: b = imm(rt, ALU_ADD);
      6'h0D: b = imm(rt, ALU_OR);
      6'h0F: b = imm(rt, ALU_LUI);
      6'h23: begin b = imm(rt, ALU_ADD); b.mr = 1'b1; b.m2r = 1'b1; end
      6'h2B: begin b.mw = 1'b1; b.asrc = 1'b1; b.alu = ALU_ADD; end
      6'h04: begin b.br = 1'b1; b.alu = ALU_SUB; end
      6'h05: begin b.br = 1'b1; b.bne = 1'b1; b.alu = ALU_SUB; end
      6'h02: b.j = 1'b1;
      6'h03: begin b.j = 1'b1; b.jal = 1'b1; b.rw = 1'b1; b.rdst = 2'b10; b.wreg = 5'd31; end
      default: b = ill();
    endcase
    return b;
  endfunction

  function automatic bit urt(input logic [31:0] w, input bit sh);
    bun_t b;
    b = dec(w, sh);
    if (w[31:26] == 6'h00) return b.rw;
    return (w[31:26] == 6'h2B) || (w[31:26] == 6'h04) || (w[31:26] == 6'h05);
  endfunction

  function automatic bit is_sys(input logic [31:0] w);
    return (w[31:26] == 6'h00) && (w[5:0] == 6'h0C);
  endfunction

  function automatic int drain_of(input int k);
    return (k == 0) ? 3 : 0;
  endfunction

  function automatic bit hz(input int k);
    logic [4:0] w;
    w = eb[k].wreg;
    return ev[k] && eb[k].mr && (w != 5'd0) &&
           ((w == instr[25:21]) || (urt(instr, k == 0) && (w == instr[20:16])));
  endfunction

  function automatic bit rdy_exp(input int k);
    return !ex_stall && !hz(k) && !insys[k];
  endfunction

  function automatic bun_t act(input int k);
    bun_t b;
    b.rdst = out_regDst[k]; b.wreg = out_wreg[k]; b.rw = out_regWrite[k]; b.mr = out_memRead[k];
    b.mw = out_memWrite[k]; b.m2r = out_memToReg[k]; b.asrc = out_ALUSrc[k]; b.alu = out_ALUop[k];
    b.br = out_branch[k]; b.bne = out_bne[k]; b.j = out_jump[k]; b.jal = out_jal[k];
    b.jr = out_jr[k]; b.ill = out_illegal[k];
    return b;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      ev[k] = 1'b0; eb[k] = '0; insys[k] = 1'b0; dl[k] = 0;
    end
  endtask

  task automatic model_edge();
    bit rdy [2];
    for (int k = 0; k < 2; k++) rdy[k] = rdy_exp(k);
    for (int k = 0; k < 2; k++) begin
      if (flush) begin
        ev[k] = 1'b0; insys[k] = 1'b0; dl[k] = 0;
      end else begin
        if (insys[k]) begin
          if (dl[k] == 0) insys[k] = 1'b0;
          else if (!ex_stall) dl[k]--;
        end
        if (!ex_stall) begin
          if (in_valid && rdy[k]) begin
            ev[k] = 1'b1;
            eb[k] = dec(instr, k == 0);
            if (is_sys(instr)) begin insys[k] = 1'b1; dl[k] = drain_of(k); end
          end else begin
            ev[k] = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("out_valid[%0d]", k), 32'(out_valid[k]), 32'(ev[k]));
      chk($sformatf("in_ready[%0d]", k), 32'(in_ready[k]), 32'(rdy_exp(k)));
      chk($sformatf("sys_fire[%0d]", k), 32'(sys_fire[k]), 32'(insys[k] && dl[k] == 0 && !flush));
      if (ev[k]) chk($sformatf("bundle[%0d]", k), 32'(act(k)), 32'(eb[k]));
    end
  endtask

  task automatic look();
    @(negedge clk);
    check_all();
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst_b = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_valid[%0d]", k), 32'(out_valid[k]), 32'd0);
      chk($sformatf("rst_bundle[%0d]", k), 32'(act(k)), 32'd0);
      chk($sformatf("rst_fire[%0d]", k), 32'(sys_fire[k]), 32'd0);
    end
    model_reset();
    #1;
    rst_b = 1'b1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0] rs, rt, rd;
    logic [5:0] fns [5];
    fns[0] = 6'h20; fns[1] = 6'h21; fns[2] = 6'h22; fns[3] = 6'h24; fns[4] = 6'h2A;
    rs = 5'($urandom_range(0, 3));
    rt = 5'($urandom_range(0, 3));
    rd = 5'($urandom_range(0, 3));
    case ($urandom_range(0, 14))
      0, 1:  return {6'h00, rs, rt, rd, 5'd0, fns[$urandom_range(0, 4)]};
      2:     return {6'h00, rs, rt, rd, 5'd0, 6'h25};
      3:     return {6'h00, 5'd0, rt, rd, 5'($urandom_range(0, 31)), 6'($urandom_range(0, 3))};
      4:     return {6'h00, rs, 15'd0, 6'h08};
      5:     return {6'h08 | 6'($urandom_range(0, 1)), rs, rt, 16'($urandom)};
      6:     return {($urandom_range(0, 1) != 0) ? 6'h0D : 6'h0F, rs, rt, 16'($urandom)};
      7, 8:  return {6'h23, rs, rt, 16'($urandom)};
      9:     return {6'h2B, rs, rt, 16'($urandom)};
      10:    return {6'h04 | 6'($urandom_range(0, 1)), rs, rt, 16'($urandom)};
      11:    return {6'h02 | 6'($urandom_range(0, 1)), 26'($urandom)};
      12:    return {6'h3F, 26'($urandom)};
      13:    return ($urandom_range(0, 3) == 0) ? 32'h0000_000C : {6'h00, rs, rt, rd, 5'd0, 6'h3F};
      default: return {6'h00, rs, rt, rd, 5'd0, 6'h20};
    endcase
  endfunction

  initial begin
    bit hold;
    rst_b = 1'b1; in_valid = 1'b0; ex_stall = 1'b0; flush = 1'b0; instr = '0;
    #1;
    do_reset();

    // add $8,$9,$10
    instr = 32'h012A_4020; in_valid = 1'b1;
    look(); chk("add_ready", 32'(in_ready[0]), 32'd1); tick();
    // lw $8,0($9) then dependent add $10,$8,$8
    instr = 32'h8D28_0000;
    look();
    chk("add_valid", 32'(out_valid[0]), 32'd1); chk("add_regdst", 32'(out_regDst[0]), 32'd1);
    chk("add_wreg", 32'(out_wreg[0]), 32'd8); chk("add_rw", 32'(out_regWrite[0]), 32'd1);
    chk("add_alu", 32'(out_ALUop[0]), 32'(ALU_ADD));
    tick();
    instr = 32'h0108_5020;
    look(); chk("lu_ready_lo", 32'(in_ready[0]), 32'd0); chk("lw_memread", 32'(out_memRead[0]), 32'd1); tick();
    look(); chk("lu_bubble", 32'(out_valid[0]), 32'd0); chk("lu_ready_hi", 32'(in_ready[0]), 32'd1); tick();
    in_valid = 1'b0; ex_stall = 1'b1;
    look(); chk("lu_add_valid", 32'(out_valid[0]), 32'd1); chk("lu_add_wreg", 32'(out_wreg[0]), 32'd10); tick();
    do_reset();
    ex_stall = 1'b0;

    // jal then flush
    instr = 32'h0C00_0010; in_valid = 1'b1;
    look(); tick();
    flush = 1'b1; instr = 32'h012A_4020;
    look();
    chk("jal_jump", 32'(out_jump[0]), 32'd1); chk("jal_jal", 32'(out_jal[0]), 32'd1);
    chk("jal_rw", 32'(out_regWrite[0]), 32'd1); chk("jal_wreg", 32'(out_wreg[0]), 32'd31);
    chk("jal_regdst", 32'(out_regDst[0]), 32'd2);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    look(); chk("flush_valid", 32'(out_valid[0]), 32'd0); tick();

    // syscall drain and fire
    instr = 32'h0000_000C; in_valid = 1'b1;
    look(); chk("sys_accept", 32'(in_ready[0]), 32'd1); tick();
    in_valid = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      look();
      chk($sformatf("sys_fire_c%0d", i), 32'(sys_fire[0]), 32'(i == 4));
      chk($sformatf("sys_fire0_c%0d", i), 32'(sys_fire[1]), 32'(i == 1));
      chk($sformatf("sys_ready_c%0d", i), 32'(in_ready[0]), 32'(i > 4));
      if (i == 1) chk("sys_bundle", 32'(act(0)), 32'd0);
      tick();
    end
    in_valid = 1'b1;
    look(); tick();
    in_valid = 1'b0;
    look(); tick();
    flush = 1'b1;
    look(); tick();
    flush = 1'b0;
    for (int i = 0; i < 5; i++) begin
      look(); chk($sformatf("sys_nofire_%0d", i), 32'(sys_fire[0]), 32'd0); tick();
    end

    // illegal, sll with/without shift support, stall hold
    instr = 32'hFC00_0000; in_valid = 1'b1;
    look(); tick();
    instr = 32'h0008_4080;
    look();
    chk("ill_flag", 32'(out_illegal[0]), 32'd1); chk("ill_valid", 32'(out_valid[0]), 32'd1);
    chk("ill_rw", 32'(out_regWrite[0]), 32'd0); chk("ill_jump", 32'(out_jump[0]), 32'd0);
    tick();
    ex_stall = 1'b1; instr = 32'h012A_4020;
    for (int i = 0; i < 2; i++) begin
      look();
      chk($sformatf("sll_wreg_%0d", i), 32'(out_wreg[0]), 32'd8);
      chk($sformatf("sll_alu_%0d", i), 32'(out_ALUop[0]), 32'(ALU_SLL));
      chk($sformatf("sll_ns_ill_%0d", i), 32'(out_illegal[1]), 32'd1);
      chk($sformatf("stall_ready_%0d", i), 32'(in_ready[0]), 32'd0);
      tick();
    end
    ex_stall = 1'b0;

    // randomized traffic
    hold = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if (!hold) begin
        instr = rand_instr();
        in_valid = ($urandom_range(0, 99) < 85);
      end
      ex_stall = ($urandom_range(0, 99) < 15);
      flush = ($urandom_range(0, 99) < 5);
      look();
      hold = in_valid && !rdy_exp(0) && !flush && ($urandom_range(0, 9) != 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
